// File: rtl/ads8861_spi_ctrl.sv
// ADS8861 conversion and readout controller: CONVST pulse, SCK generation,
// 16-bit MSB-first capture in 3-wire CS mode without busy indicator.
module ads8861_spi_ctrl #(
  parameter int unsigned T_CONV  = 72,
  parameter int unsigned CLK_DIV = 1,
  parameter int unsigned DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sdo,
  output logic              din,
  output logic              convst,
  output logic              sck,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              idle,
  output logic              start_miss
);

  localparam int unsigned CNT_MAX = (T_CONV > CLK_DIV) ? T_CONV : CLK_DIV;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int unsigned BIT_W   = 5;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_SETUP, S_SHIFT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bits_q, bits_d;
  logic [DATA_W-1:0]  sr_q, sr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               convst_q, convst_d;
  logic               sck_q, sck_d;
  logic               data_valid_q, data_valid_d;
  logic               idle_q, idle_d;
  logic               start_miss_q, start_miss_d;

  // Next-state and registered-output logic; cnt times both CONV and SCK phases
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    bits_d       = bits_q;
    sr_d         = sr_q;
    data_d       = data_q;
    convst_d     = convst_q;
    sck_d        = sck_q;
    data_valid_d = 1'b0;
    idle_d       = idle_q;
    start_miss_d = start && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d  = S_CONV;
          convst_d = 1'b1;
          idle_d   = 1'b0;
          bits_d   = '0;
          sr_d     = '0;
        end
      end
      S_CONV: begin
        if (cnt_q == CNT_W'(T_CONV - 1)) begin
          convst_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          sck_d   = 1'b1;
          sr_d    = {sr_q[DATA_W-2:0], sdo};
          bits_d  = BIT_W'(1);
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (sck_q) begin
            sck_d = 1'b0;
          end else if (bits_q == BIT_W'(DATA_W)) begin
            data_d       = sr_q;
            data_valid_d = 1'b1;
            idle_d       = 1'b1;
            state_d      = S_IDLE;
          end else begin
            sck_d  = 1'b1;
            sr_d   = {sr_q[DATA_W-2:0], sdo};
            bits_d = bits_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        convst_d = 1'b0;
        sck_d    = 1'b0;
        idle_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bits_q       <= '0;
      sr_q         <= '0;
      data_q       <= '0;
      convst_q     <= 1'b0;
      sck_q        <= 1'b0;
      data_valid_q <= 1'b0;
      idle_q       <= 1'b1;
      start_miss_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bits_q       <= bits_d;
      sr_q         <= sr_d;
      data_q       <= data_d;
      convst_q     <= convst_d;
      sck_q        <= sck_d;
      data_valid_q <= data_valid_d;
      idle_q       <= idle_d;
      start_miss_q <= start_miss_d;
    end
  end

  // DIN tied high selects 3-wire CS mode
  assign din        = 1'b1;
  assign convst     = convst_q;
  assign sck        = sck_q;
  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign idle       = idle_q;
  assign start_miss = start_miss_q;

endmodule
